game_sequencer: RTL and testbench

Central scheduler for one snake game frame. It owns the game tick and sequences the per-tick pipeline: snake step, field rebuild, collision/apple check, then apple placement. Every stage is a pulse/done handshake with a watchdog. It also tracks score, speeds up the tick per apple eaten, and handles start, pause, game-over and win.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/game_tick_gen.sv | 53 +++++
 rtl/game_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game frame sequencer.
// State codes are visible on the sequencer's state output, so their values are fixed.
package snake_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        RUN   = 4'd2,
        STEP  = 4'd3,
        FIELD = 4'd4,
        CHECK = 4'd5,
        APPLE = 4'd6,
        PAUSE = 4'd7,
        OVER  = 4'd8,
        WON   = 4'd9,
        ERR   = 4'd10
    } state_e;

    localparam int TICK_BASE_DEF = 12000000;
    localparam int TICK_MIN_DEF  = 3000000;
    localparam int TICK_DEC_DEF  = 500000;
    localparam int TIMEOUT_DEF   = 1024;
    localparam int SCORE_W_DEF   = 16;
    localparam int PERIOD_W      = 32;

    // States that wait on a done handshake and are guarded by the watchdog.
    function automatic logic is_wait(input state_e s);
        return s inside {STEP, FIELD, CHECK, APPLE};
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Programmable-period tick divider: owns the tick period, which shrinks per apple
// and never drops below the floor.
module game_tick_gen
    import snake_pkg::*;
#(
    parameter int TICK_BASE = TICK_BASE_DEF,
    parameter int TICK_MIN  = TICK_MIN_DEF,
    parameter int TICK_DEC  = TICK_DEC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [PERIOD_W-1:0] BASE_P = PERIOD_W'(TICK_BASE);
    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(TICK_MIN);
    localparam logic [PERIOD_W-1:0] DEC_P  = PERIOD_W'(TICK_DEC);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] count_q, count_d;

    // Compare before subtracting so a small period cannot wrap around.
    function automatic logic [PERIOD_W-1:0] dec_clamp(input logic [PERIOD_W-1:0] p);
        if (p < MIN_P + DEC_P) return MIN_P;
        return p - DEC_P;
    endfunction

    assign tick_o = (count_q == period_q - 1'b1);

    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        if (load_i)     period_d = BASE_P;
        else if (dec_i) period_d = dec_clamp(period_q);
        if (clr_i)      count_d = '0;
        else if (en_i)  count_d = tick_o ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= BASE_P;
            count_q  <= '0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Per-frame scheduler: runs the tick, sequences snake/field/check/apple handshakes,
// keeps score and handles start, pause, game-over, win and watchdog error.
module game_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_BASE = TICK_BASE_DEF,
    parameter int TICK_MIN  = TICK_MIN_DEF,
    parameter int TICK_DEC  = TICK_DEC_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int SCORE_W   = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_req,
    input  logic               pause_req,
    output logic               snake_step,
    input  logic               snake_done,
    output logic               field_step,
    input  logic               field_done,
    output logic               check,
    input  logic               check_done,
    input  logic               dead,
    input  logic               grow,
    output logic               apple_req,
    input  logic               apple_done,
    input  logic               apple_fail,
    output logic               game_init,
    output logic [3:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               game_won,
    output logic               err_timeout
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e             state_q, state_d, rb;
    logic               latch_q, latch_d, latch_eff;
    logic               from_init_q, from_init_d;
    logic               err_q, err_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               snake_step_q, field_step_q, check_q, apple_req_q, game_init_q;
    logic               over_q, won_q;
    logic               tick, tick_en, tick_clr, dec, enter;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + 1'b1;
    endfunction

    game_tick_gen #(
        .TICK_BASE (TICK_BASE),
        .TICK_MIN  (TICK_MIN),
        .TICK_DEC  (TICK_DEC)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (start_req),
        .dec_i  (dec),
        .clr_i  (tick_clr),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        latch_d     = latch_q;
        from_init_d = from_init_q;
        err_d       = err_q;
        wd_d        = wd_q;
        score_d     = score_q;
        tick_en     = 1'b0;
        dec         = 1'b0;
        // A pause request that lands with the done still diverts this transition.
        latch_eff   = latch_q ^ (pause_req && is_wait(state_q));
        rb          = latch_eff ? PAUSE : RUN;

        case (state_q)
            INIT: begin
                state_d     = FIELD;
                from_init_d = 1'b1;
            end
            RUN: begin
                if (pause_req) state_d = PAUSE;
                else begin
                    tick_en = 1'b1;
                    if (tick) state_d = STEP;
                end
            end
            PAUSE: if (pause_req) state_d = RUN;
            STEP: begin
                if (snake_done) begin
                    state_d     = FIELD;
                    from_init_d = 1'b0;
                end
            end
            FIELD: if (field_done) state_d = from_init_q ? rb : CHECK;
            CHECK: begin
                if (check_done) begin
                    if (dead) state_d = OVER;
                    else if (grow) begin
                        state_d = APPLE;
                        score_d = sat_inc(score_q);
                        dec     = 1'b1;
                    end else state_d = rb;
                end
            end
            APPLE: if (apple_done) state_d = apple_fail ? WON : rb;
            default: ;
        endcase

        if (is_wait(state_q)) begin
            latch_d = latch_eff;
            if (state_d == state_q) begin
                if (wd_q == WD_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
                wd_d = wd_q + 1'b1;
            end
        end
        if (state_d != state_q) wd_d = '0;
        if (state_d == PAUSE)   latch_d = 1'b0;

        if (start_req) begin
            state_d = INIT;
            score_d = '0;
            err_d   = 1'b0;
            latch_d = 1'b0;
            wd_d    = '0;
        end

        enter    = (state_d != state_q) || start_req;
        // Resuming from PAUSE keeps the count; any other way into RUN/PAUSE restarts it.
        tick_clr = start_req ||
                   ((state_d == RUN || state_d == PAUSE) && !(state_q == RUN || state_q == PAUSE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            latch_q      <= 1'b0;
            from_init_q  <= 1'b0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            score_q      <= '0;
            snake_step_q <= 1'b0;
            field_step_q <= 1'b0;
            check_q      <= 1'b0;
            apple_req_q  <= 1'b0;
            game_init_q  <= 1'b0;
            over_q       <= 1'b0;
            won_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_q      <= latch_d;
            from_init_q  <= from_init_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            score_q      <= score_d;
            snake_step_q <= enter && (state_d == STEP);
            field_step_q <= enter && (state_d == FIELD);
            check_q      <= enter && (state_d == CHECK);
            apple_req_q  <= enter && (state_d == APPLE);
            game_init_q  <= enter && (state_d == INIT);
            over_q       <= (state_d == OVER);
            won_q        <= (state_d == WON);
        end
    end

    assign state       = state_q;
    assign score       = score_q;
    assign snake_step  = snake_step_q;
    assign field_step  = field_step_q;
    assign check       = check_q;
    assign apple_req   = apple_req_q;
    assign game_init   = game_init_q;
    assign game_over   = over_q;
    assign game_won    = won_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short tick periods and a 16-cycle watchdog.
module tb_game_sequencer;

    localparam int SNK = 0;
    localparam int FLD = 1;
    localparam int CHK = 2;
    localparam int APL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_req = 1'b0, pause_req = 1'b0;
    logic        snake_done = 1'b0, field_done = 1'b0, check_done = 1'b0;
    logic        dead = 1'b0, grow = 1'b0, apple_done = 1'b0, apple_fail = 1'b0;
    logic        snake_step, field_step, check, apple_req, game_init;
    logic [3:0]  state;
    logic [15:0] score;
    logic        game_over, game_won, err_timeout;

    int checks = 0;
    int errors = 0;
    int n;
    int exp_period [3] = '{7, 4, 4};

    game_sequencer #(
        .TICK_BASE (10),
        .TICK_MIN  (4),
        .TICK_DEC  (3),
        .TIMEOUT   (16),
        .SCORE_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_req   (start_req),
        .pause_req   (pause_req),
        .snake_step  (snake_step),
        .snake_done  (snake_done),
        .field_step  (field_step),
        .field_done  (field_done),
        .check       (check),
        .check_done  (check_done),
        .dead        (dead),
        .grow        (grow),
        .apple_req   (apple_req),
        .apple_done  (apple_done),
        .apple_fail  (apple_fail),
        .game_init   (game_init),
        .state       (state),
        .score       (score),
        .game_over   (game_over),
        .game_won    (game_won),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Responder: done arrives one cycle after the request pulse.
    task automatic reply(input int which, input logic d, input logic g, input logic f);
        cyc();
        case (which)
            SNK: snake_done = 1'b1;
            FLD: field_done = 1'b1;
            CHK: begin check_done = 1'b1; dead = d; grow = g; end
            default: begin apple_done = 1'b1; apple_fail = f; end
        endcase
        cyc();
        snake_done = 1'b0; field_done = 1'b0; check_done = 1'b0;
        dead = 1'b0; grow = 1'b0; apple_done = 1'b0; apple_fail = 1'b0;
    endtask

    task automatic wait_step(output int cnt);
        cnt = 0;
        while (cnt < 40) begin
            cyc();
            cnt++;
            if (snake_step) break;
        end
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        cyc();
        start_req = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        cyc(); cyc();
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_pulses", int'({snake_step, field_step, check, apple_req, game_init}), 0);
        chk("rst_flags", int'({game_over, game_won, err_timeout}), 0);
        rst = 1'b1;
        cyc();

        // Start: INIT, FIELD (initial board), RUN, first tick after 10 cycles
        pulse_start();
        chk("init_state", int'(state), 1);
        chk("init_pulse", int'(game_init), 1);
        cyc();
        chk("init_field_state", int'(state), 4);
        chk("init_field_pulse", int'(field_step), 1);
        chk("init_pulse_once", int'(game_init), 0);
        reply(FLD, 0, 0, 0);
        chk("run_entry", int'(state), 2);
        wait_step(n);
        chk("first_tick", n, 10);
        chk("step_state", int'(state), 3);
        reply(SNK, 0, 0, 0);
        chk("field_after_step", int'(state), 4);
        chk("field_pulse", int'(field_step), 1);
        reply(FLD, 0, 0, 0);
        chk("check_state", int'(state), 5);
        chk("check_pulse", int'(check), 1);

        // Three apples: score climbs, period 7, 4, 4
        for (int i = 0; i < 3; i++) begin
            reply(CHK, 1'b0, 1'b1, 1'b0);
            chk("grow_state", int'(state), 6);
            chk("grow_apple_req", int'(apple_req), 1);
            chk("grow_score", int'(score), i + 1);
            reply(APL, 0, 0, 1'b0);
            chk("apple_to_run", int'(state), 2);
            wait_step(n);
            chk("grow_period", n, exp_period[i]);
            reply(SNK, 0, 0, 0);
            reply(FLD, 0, 0, 0);
        end

        // dead and grow together: dead wins
        reply(CHK, 1'b1, 1'b1, 1'b0);
        chk("over_state", int'(state), 8);
        chk("over_flag", int'(game_over), 1);
        chk("over_score", int'(score), 3);
        chk("over_no_apple", int'(apple_req), 0);
        cyc();
        chk("over_no_apple_later", int'(apple_req), 0);
        pulse_start();
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_over_clr", int'(game_over), 0);
        cyc();
        reply(FLD, 0, 0, 0);
        chk("restart_run", int'(state), 2);
        wait_step(n);
        chk("restart_period", n, 10);
        reply(SNK, 0, 0, 0);
        reply(FLD, 0, 0, 0);

        // Pause latched during CHECK diverts to PAUSE
        pulse_pause();
        check_done = 1'b1;
        cyc();
        check_done = 1'b0;
        chk("latched_pause", int'(state), 7);
        cyc(); cyc(); cyc();
        chk("pause_holds", int'(state), 7);
        pulse_pause();
        chk("resume_run", int'(state), 2);
        repeat (4) cyc();
        pulse_pause();
        chk("run_pause", int'(state), 7);
        repeat (3) cyc();
        pulse_pause();
        chk("resume_run2", int'(state), 2);
        wait_step(n);
        chk("resume_from_frozen", n, 6);

        // Watchdog on a withheld field_done
        reply(SNK, 0, 0, 0);
        repeat (15) cyc();
        chk("wd_not_yet", int'(state), 4);
        cyc();
        chk("wd_err_state", int'(state), 10);
        chk("wd_err_flag", int'(err_timeout), 1);
        pulse_pause();
        repeat (3) cyc();
        chk("err_stays", int'(state), 10);
        chk("err_sticky", int'(err_timeout), 1);
        pulse_start();
        chk("err_restart_state", int'(state), 1);
        chk("err_restart_flag", int'(err_timeout), 0);
        cyc();
        reply(FLD, 0, 0, 0);
        chk("err_restart_run", int'(state), 2);

        // One apple, then async reset in the middle of STEP
        wait_step(n);
        snake_done = 1'b1;
        cyc();
        snake_done = 1'b0;
        chk("same_cycle_done", int'(state), 4);
        reply(FLD, 0, 0, 0);
        reply(CHK, 1'b0, 1'b1, 1'b0);
        reply(APL, 0, 0, 1'b0);
        wait_step(n);
        chk("pre_reset_period", n, 7);
        chk("pre_reset_score", int'(score), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_step", int'(snake_step), 0);
        chk("async_rst_score", int'(score), 0);
        #1 rst = 1'b1;
        cyc(); cyc(); cyc();
        chk("post_rst_idle", int'(state), 0);
        chk("post_rst_no_pulse", int'({snake_step, field_step, check, apple_req, game_init}), 0);

        // Win: no empty cell for the apple
        pulse_start();
        cyc();
        reply(FLD, 0, 0, 0);
        wait_step(n);
        chk("post_rst_period", n, 10);
        reply(SNK, 0, 0, 0);
        reply(FLD, 0, 0, 0);
        reply(CHK, 1'b0, 1'b1, 1'b0);
        reply(APL, 0, 0, 1'b1);
        chk("won_state", int'(state), 9);
        chk("won_flag", int'(game_won), 1);
        chk("won_score", int'(score), 1);
        cyc();
        chk("won_holds", int'(game_won), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
